// File: rtl/pool_pkg.sv
// Shared definitions for the ReLU + 2x2 max-pool stage: default sample width,
// counter-width helper and the signed ReLU / max helpers.
package pool_pkg;

    localparam int D_BW_DEFAULT = 16;
    // Helpers work on a wide signed type so any D_BW up to 32 can use them.
    localparam int FN_BW = 32;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [FN_BW-1:0] relu(input logic signed [FN_BW-1:0] x);
        return (x < 32'sd0) ? {FN_BW{1'b0}} : x;
    endfunction

    function automatic logic signed [FN_BW-1:0] max2(input logic signed [FN_BW-1:0] a,
                                                     input logic signed [FN_BW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row store of horizontal pair maxima: synchronous write, asynchronous read.
module pool_line_buffer #(
    parameter int D_BW  = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [D_BW-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [D_BW-1:0] rd_data
);

    logic [D_BW-1:0] mem_r [DEPTH];

    // Contents need no reset: every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/relu_maxpool_2x2.sv
// Streaming ReLU followed by 2x2 stride-2 max pooling over a raster-order
// feature map, using one half-width row of partial maxima.
module relu_maxpool_2x2
    import pool_pkg::*;
#(
    parameter int D_BW  = D_BW_DEFAULT,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic signed [D_BW-1:0] i_data,
    output logic                   o_valid,
    output logic        [D_BW-1:0] o_data,
    output logic                   o_last
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam int HW = IMG_W / 2;
    localparam int AW = cnt_w(HW);

    logic        [CW-1:0]   col_r;
    logic        [RW-1:0]   row_r;
    logic signed [D_BW-1:0] hmax_r;

    logic signed [D_BW-1:0] relu_s;
    logic signed [D_BW-1:0] pair_max_s;
    logic signed [D_BW-1:0] win_max_s;
    logic signed [D_BW-1:0] lb_rd_s;
    logic        [AW-1:0]   lb_addr_s;
    logic                   lb_wr_en_s;
    logic                   last_col_s;
    logic                   last_row_s;

    // Datapath: ReLU, horizontal pair max, full-window max and line-buffer control.
    always_comb begin
        relu_s     = D_BW'(relu(FN_BW'(i_data)));
        pair_max_s = D_BW'(max2(FN_BW'(hmax_r), FN_BW'(relu_s)));
        win_max_s  = D_BW'(max2(FN_BW'(lb_rd_s), FN_BW'(pair_max_s)));
        lb_addr_s  = AW'(col_r >> 1);
        last_col_s = (col_r == CW'(IMG_W - 1));
        last_row_s = (row_r == RW'(IMG_H - 1));
        lb_wr_en_s = i_valid & ~i_rst & col_r[0] & ~row_r[0];
    end

    pool_line_buffer #(
        .D_BW  (D_BW),
        .DEPTH (HW),
        .AW    (AW)
    ) u_line_buf (
        .clk     (i_clk),
        .wr_en   (lb_wr_en_s),
        .wr_addr (lb_addr_s),
        .wr_data (pair_max_s),
        .rd_addr (lb_addr_s),
        .rd_data (lb_rd_s)
    );

    // Raster counters, pending-pair register and registered pooled outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_r   <= {CW{1'b0}};
            row_r   <= {RW{1'b0}};
            hmax_r  <= {D_BW{1'b0}};
            o_data  <= {D_BW{1'b0}};
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            if (i_valid) begin
                if (last_col_s) begin
                    col_r <= {CW{1'b0}};
                    row_r <= last_row_s ? {RW{1'b0}} : row_r + RW'(1'b1);
                end else begin
                    col_r <= col_r + CW'(1'b1);
                end
                if (!col_r[0]) begin
                    hmax_r <= relu_s;
                end
                // Bottom-right of a window: emit the max of all four samples.
                if (col_r[0] && row_r[0]) begin
                    o_data  <= win_max_s;
                    o_valid <= 1'b1;
                    o_last  <= last_row_s & last_col_s;
                end
            end
        end
    end

endmodule
